// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : 800x600@60 raster constants and the framebuffer pixel type.
// Revision    : 1.0
// ============================================================================
package fb_pkg;

    localparam int FB_H_ACTIVE = 800;
    localparam int FB_H_FP     = 40;
    localparam int FB_H_SYNC   = 128;
    localparam int FB_H_BP     = 88;

    localparam int FB_V_ACTIVE = 600;
    localparam int FB_V_FP     = 1;
    localparam int FB_V_SYNC   = 4;
    localparam int FB_V_BP     = 23;

    localparam int FB_ADDR_W   = 19;
    localparam int FB_PIXELS   = 480000;

    // One byte per pixel, RRRGGGBB
    typedef logic [7:0] color_t;

endpackage
`default_nettype wire

// File: rtl/fb_scanout_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout_if
// Description : Framebuffer read port plus video output bundle of fb_scanout.
//               Swap signals exist only when FB_SCANOUT_SWAP_EN is defined.
// Revision    : 1.0
// ============================================================================
interface fb_scanout_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
);

    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    color_t            fb_data;
    logic              hsync;
    logic              vsync;
    logic              de;
    color_t            color;
    logic              frame_start;
    logic              line_end;
`ifdef FB_SCANOUT_SWAP_EN
    logic              swap_req;
    logic              swap_ack;
    logic              buf_sel;

    modport master (
        output fb_addr, fb_rd_en, hsync, vsync, de, color, frame_start, line_end,
        output swap_ack, buf_sel,
        input  fb_data, swap_req
    );

    modport slave (
        input  fb_addr, fb_rd_en, hsync, vsync, de, color, frame_start, line_end,
        input  swap_ack, buf_sel,
        output fb_data, swap_req
    );
`else
    modport master (
        output fb_addr, fb_rd_en, hsync, vsync, de, color, frame_start, line_end,
        input  fb_data
    );

    modport slave (
        input  fb_addr, fb_rd_en, hsync, vsync, de, color, frame_start, line_end,
        output fb_data
    );
`endif

endinterface
`default_nettype wire

// File: rtl/vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vid_timing_gen
// Description : Raster h/v counters with combinational active/sync/first/last
//               flags describing the current counter position.
// Revision    : 1.0
// ============================================================================
module vid_timing_gen
    import fb_pkg::*;
#(
    parameter int H_ACTIVE = FB_H_ACTIVE,
    parameter int H_FP     = FB_H_FP,
    parameter int H_SYNC   = FB_H_SYNC,
    parameter int H_BP     = FB_H_BP,
    parameter int V_ACTIVE = FB_V_ACTIVE,
    parameter int V_FP     = FB_V_FP,
    parameter int V_SYNC   = FB_V_SYNC,
    parameter int V_BP     = FB_V_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      o_active,
    output logic      o_hsync,
    output logic      o_vsync,
    output logic      o_first,
    output logic      o_last,
    output logic      o_wrap
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] C_H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] C_H_LAST_ACT = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] C_H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] C_HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] C_HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] C_V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] C_V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] C_VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] C_VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_h_act;
    logic          w_v_act;

    assign w_h_wrap = (r_h_cnt == C_H_LAST);
    assign w_v_wrap = (r_v_cnt == C_V_LAST);
    assign w_h_act  = (r_h_cnt < C_H_ACT);
    assign w_v_act  = (r_v_cnt < C_V_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_active = w_h_act && w_v_act;
    assign o_hsync  = ((r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign o_vsync  = ((r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign o_first  = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_last   = (r_h_cnt == C_H_LAST_ACT) && w_v_act;
    assign o_wrap   = w_h_wrap && w_v_wrap;

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout
// Description : Framebuffer scanout: raster timing, linear read addressing and
//               a BRAM-latency-matched output pipeline. Optional double-buffer
//               swap under FB_SCANOUT_SWAP_EN (needs ADDR_W >= 20).
// Revision    : 1.0
// ============================================================================
module fb_scanout
    import fb_pkg::*;
#(
    parameter int H_ACTIVE = FB_H_ACTIVE,
    parameter int H_FP     = FB_H_FP,
    parameter int H_SYNC   = FB_H_SYNC,
    parameter int H_BP     = FB_H_BP,
    parameter int V_ACTIVE = FB_V_ACTIVE,
    parameter int V_FP     = FB_V_FP,
    parameter int V_SYNC   = FB_V_SYNC,
    parameter int V_BP     = FB_V_BP,
    parameter int ADDR_W   = FB_ADDR_W,
    parameter bit SYNC_POL = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fb_scanout_if.master  vid
);

    logic w_active;
    logic w_hsync;
    logic w_vsync;
    logic w_first;
    logic w_last;
    logic w_wrap;

    vid_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .o_active (w_active),
        .o_hsync  (w_hsync),
        .o_vsync  (w_vsync),
        .o_first  (w_first),
        .o_last   (w_last),
        .o_wrap   (w_wrap)
    );

    logic [ADDR_W-1:0] w_base;

`ifdef FB_SCANOUT_SWAP_EN
    localparam logic [ADDR_W-1:0] C_BUF1_BASE = ADDR_W'(H_ACTIVE * V_ACTIVE);

    logic r_buf_sel;
    logic r_swap_pend;
    logic r_swap_ack;

    // Requests collapse into one pending flag; the buffer flips exactly at the raster wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_sel   <= 1'b0;
            r_swap_pend <= 1'b0;
            r_swap_ack  <= 1'b0;
        end else begin
            r_swap_ack <= 1'b0;
            if (w_wrap && (r_swap_pend || vid.swap_req)) begin
                r_buf_sel   <= ~r_buf_sel;
                r_swap_ack  <= 1'b1;
                r_swap_pend <= 1'b0;
            end else if (vid.swap_req) begin
                r_swap_pend <= 1'b1;
            end
        end
    end

    assign w_base       = r_buf_sel ? C_BUF1_BASE : '0;
    assign vid.swap_ack = r_swap_ack;
    assign vid.buf_sel  = r_buf_sel;
`else
    assign w_base = '0;
`endif

    // Stage 0: linear address counter, restarted at the first pixel of each frame
    logic [ADDR_W-1:0] r_pix_cnt;
    logic [ADDR_W-1:0] w_pix_idx;
    logic [ADDR_W-1:0] r_fb_addr;
    logic              r_fb_rd_en;
    logic              r_s0_hsync;
    logic              r_s0_vsync;
    logic              r_s0_first;
    logic              r_s0_last;

    assign w_pix_idx = w_first ? '0 : r_pix_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= '0;
            r_fb_addr  <= '0;
            r_fb_rd_en <= 1'b0;
            r_s0_hsync <= ~SYNC_POL;
            r_s0_vsync <= ~SYNC_POL;
            r_s0_first <= 1'b0;
            r_s0_last  <= 1'b0;
        end else begin
            r_fb_rd_en <= w_active;
            if (w_active) begin
                r_fb_addr <= w_base + w_pix_idx;
                r_pix_cnt <= w_pix_idx + 1'b1;
            end
            r_s0_hsync <= w_hsync;
            r_s0_vsync <= w_vsync;
            r_s0_first <= w_first;
            r_s0_last  <= w_last;
        end
    end

    // Stage 1: control rides alongside the BRAM read
    logic r_s1_active;
    logic r_s1_hsync;
    logic r_s1_vsync;
    logic r_s1_first;
    logic r_s1_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_active <= 1'b0;
            r_s1_hsync  <= ~SYNC_POL;
            r_s1_vsync  <= ~SYNC_POL;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
        end else begin
            r_s1_active <= r_fb_rd_en;
            r_s1_hsync  <= r_s0_hsync;
            r_s1_vsync  <= r_s0_vsync;
            r_s1_first  <= r_s0_first;
            r_s1_last   <= r_s0_last;
        end
    end

    // Stage 2: outputs land two cycles after fb_addr, matching the read data
    color_t r_color;
    logic   r_de;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_start;
    logic   r_line_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_color       <= '0;
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
        end else begin
            r_color       <= r_s1_active ? vid.fb_data : '0;
            r_de          <= r_s1_active;
            r_hsync       <= r_s1_hsync;
            r_vsync       <= r_s1_vsync;
            r_frame_start <= r_s1_first;
            r_line_end    <= r_s1_last;
        end
    end

    assign vid.fb_addr     = r_fb_addr;
    assign vid.fb_rd_en    = r_fb_rd_en;
    assign vid.color       = r_color;
    assign vid.de          = r_de;
    assign vid.hsync       = r_hsync;
    assign vid.vsync       = r_vsync;
    assign vid.frame_start = r_frame_start;
    assign vid.line_end    = r_line_end;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_scanout
// Description : Directed self-checking bench for fb_scanout on a reduced raster.
// Revision    : 1.0
// ============================================================================
module tb_fb_scanout;
    import fb_pkg::*;

    // Reduced raster keeps a full frame short: 31 x 12 = 372 cycles, 96 pixels
    localparam int HA   = 16;
    localparam int HF   = 4;
    localparam int HS   = 6;
    localparam int HB   = 5;
    localparam int VA   = 6;
    localparam int VF   = 1;
    localparam int VS   = 2;
    localparam int VB   = 3;
    localparam int HT   = HA + HF + HS + HB;
    localparam int VT   = VA + VF + VS + VB;
    localparam int FT   = HT * VT;
    localparam int NPIX = HA * VA;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fb_scanout_if #(.ADDR_W(19)) vid ();

    fb_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .ADDR_W   (19), .SYNC_POL (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vid.master)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM model: data = low byte of address
    always @(posedge clk) begin
        if (vid.fb_rd_en) vid.fb_data <= vid.fb_addr[7:0];
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (vid.fb_addr !== 19'd0) begin bad++; $display("FAIL rst_fb_addr: got %0d want 0", vid.fb_addr); end
        total++; if (vid.fb_rd_en !== 1'b0) begin bad++; $display("FAIL rst_fb_rd_en: got %b want 0", vid.fb_rd_en); end
        total++; if (vid.hsync !== 1'b0) begin bad++; $display("FAIL rst_hsync: got %b want 0", vid.hsync); end
        total++; if (vid.vsync !== 1'b0) begin bad++; $display("FAIL rst_vsync: got %b want 0", vid.vsync); end
        total++; if (vid.de !== 1'b0) begin bad++; $display("FAIL rst_de: got %b want 0", vid.de); end
        total++; if (vid.color !== 8'h00) begin bad++; $display("FAIL rst_color: got %0h want 0", vid.color); end
        total++; if (vid.frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start: got %b want 0", vid.frame_start); end
        total++; if (vid.line_end !== 1'b0) begin bad++; $display("FAIL rst_line_end: got %b want 0", vid.line_end); end
    endtask

    task automatic test_frame();
        int pos, h, v, exp_col;
        logic exp_act, exp_hs, exp_vs;
        int rd_cnt = 0, rd_blank = 0, addr_move = 0, max_addr = 0;
        int out_bad = 0, col_bad = 0, de_cnt = 0, le_cnt = 0, fs_cnt = 0;
        int fs_first = -1, fs_second = -1, first_rd = -1, first_rd_addr = -1, first_de = -1;
        int col_first = -1, col_line1 = -1, col_last = -1;
        int de_fall = -1, hs_rise = -1, hs_fall = -1, gap = -1, vs_rise = -1, vs_fall = -1;
        logic prev_de = 1'b0, prev_hs = 1'b0, prev_vs = 1'b0;
        logic [18:0] prev_addr = '0;

        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= FT + 5; n++) begin
            @(negedge clk);
            // Stage-0 outputs describe counter position n-1
            pos = n - 1; h = pos % HT; v = (pos / HT) % VT;
            if (n <= FT && vid.fb_rd_en) rd_cnt++;
            if (vid.fb_rd_en && !(h < HA && v < VA)) rd_blank++;
            if (vid.fb_rd_en && first_rd < 0) begin first_rd = n; first_rd_addr = int'(vid.fb_addr); end
            if (!vid.fb_rd_en && vid.fb_addr !== prev_addr) addr_move++;
            if (int'(vid.fb_addr) > max_addr) max_addr = int'(vid.fb_addr);
            prev_addr = vid.fb_addr;
            // Video outputs describe counter position n-3
            if (n >= 3) begin
                pos = n - 3; h = pos % HT; v = (pos / HT) % VT;
                exp_act = (h < HA) && (v < VA);
                exp_hs  = (h >= HA + HF) && (h < HA + HF + HS);
                exp_vs  = (v >= VA + VF) && (v < VA + VF + VS);
                exp_col = exp_act ? ((h + v * HA) & 255) : 0;
                if (vid.de !== exp_act || vid.hsync !== exp_hs || vid.vsync !== exp_vs ||
                    vid.line_end !== (exp_act && h == HA - 1) ||
                    vid.frame_start !== (exp_act && h == 0 && v == 0)) out_bad++;
                if (int'(vid.color) != exp_col) col_bad++;
                if (n <= FT + 2 && vid.de) de_cnt++;
                if (n <= FT + 2 && vid.line_end) le_cnt++;
            end
            if (vid.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n; else if (fs_second < 0) fs_second = n;
            end
            if (vid.de && first_de < 0) first_de = n;
            if (n == 3) col_first = int'(vid.color);
            if (n == 3 + HT) col_line1 = int'(vid.color);
            if (n == 3 + (VA - 1) * HT + HA - 1) col_last = int'(vid.color);
            if (prev_de && !vid.de && de_fall < 0) de_fall = n;
            if (!prev_hs && vid.hsync && hs_rise < 0) begin hs_rise = n; if (de_fall >= 0) gap = n - de_fall; end
            if (prev_hs && !vid.hsync && hs_rise >= 0 && hs_fall < 0) hs_fall = n;
            if (!prev_vs && vid.vsync && vs_rise < 0) vs_rise = n;
            if (prev_vs && !vid.vsync && vs_rise >= 0 && vs_fall < 0) vs_fall = n;
            prev_de = vid.de; prev_hs = vid.hsync; prev_vs = vid.vsync;
        end

        total++; if (de_cnt != NPIX) begin bad++; $display("FAIL frame_de_count: got %0d want %0d", de_cnt, NPIX); end
        total++; if (rd_cnt != NPIX) begin bad++; $display("FAIL frame_rd_count: got %0d want %0d", rd_cnt, NPIX); end
        total++; if (le_cnt != VA) begin bad++; $display("FAIL frame_line_end_count: got %0d want %0d", le_cnt, VA); end
        total++; if (fs_cnt != 2) begin bad++; $display("FAIL frame_start_count: got %0d want 2", fs_cnt); end
        total++; if (fs_first != 3) begin bad++; $display("FAIL frame_start_first: got %0d want 3", fs_first); end
        total++; if (fs_second - fs_first != FT) begin bad++; $display("FAIL frame_period: got %0d want %0d", fs_second - fs_first, FT); end
        total++; if (first_rd != 1 || first_rd_addr != 0) begin bad++; $display("FAIL first_read: got cycle %0d addr %0d want cycle 1 addr 0", first_rd, first_rd_addr); end
        total++; if (first_de != 3) begin bad++; $display("FAIL first_de: got %0d want 3", first_de); end
        total++; if (out_bad != 0) begin bad++; $display("FAIL sync_alignment: got %0d bad cycles want 0", out_bad); end
        total++; if (col_bad != 0) begin bad++; $display("FAIL color_stream: got %0d bad cycles want 0", col_bad); end
        total++; if (col_first != 8'h00) begin bad++; $display("FAIL color_first: got %0h want 00", col_first); end
        total++; if (col_line1 != 8'h10) begin bad++; $display("FAIL color_line1: got %0h want 10", col_line1); end
        total++; if (col_last != 8'h5F) begin bad++; $display("FAIL color_last: got %0h want 5f", col_last); end
        total++; if (hs_fall - hs_rise != HS) begin bad++; $display("FAIL hsync_width: got %0d want %0d", hs_fall - hs_rise, HS); end
        total++; if (gap != HF) begin bad++; $display("FAIL h_front_porch: got %0d want %0d", gap, HF); end
        total++; if (vs_fall - vs_rise != VS * HT) begin bad++; $display("FAIL vsync_width: got %0d want %0d", vs_fall - vs_rise, VS * HT); end
        total++; if (rd_blank != 0) begin bad++; $display("FAIL rd_en_blanking: got %0d cycles want 0", rd_blank); end
        total++; if (addr_move != 0) begin bad++; $display("FAIL addr_hold_blanking: got %0d moves want 0", addr_move); end
        total++; if (max_addr != NPIX - 1) begin bad++; $display("FAIL addr_max: got %0d want %0d", max_addr, NPIX - 1); end
    endtask

    task automatic test_reset_mid();
        // Outputs are mid-stream when reset lands; async reset must clear them at once
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (vid.de !== 1'b0 || vid.fb_rd_en !== 1'b0) begin bad++; $display("FAIL async_reset: got de=%b rd_en=%b want 0 0", vid.de, vid.fb_rd_en); end
        @(negedge clk);
        rst_n = 1'b1;
        // Counter reaches (8,3); output shows pixel (5,3) = 5 + 3*16 = 0x35
        for (int n = 1; n <= 3 * HT + 8; n++) @(negedge clk);
        total++; if (vid.de !== 1'b1 || vid.color !== 8'h35) begin bad++; $display("FAIL mid_frame_pixel: got de=%b color=%0h want 1 35", vid.de, vid.color); end
        rst_n = 1'b0;
        #1;
        total++; if (vid.fb_addr !== 19'd0 || vid.fb_rd_en !== 1'b0 || vid.color !== 8'h00) begin bad++; $display("FAIL mid_reset_data: got addr=%0d rd_en=%b color=%0h want 0 0 0", vid.fb_addr, vid.fb_rd_en, vid.color); end
        total++; if (vid.de !== 1'b0 || vid.hsync !== 1'b0 || vid.vsync !== 1'b0 || vid.frame_start !== 1'b0 || vid.line_end !== 1'b0) begin
            bad++; $display("FAIL mid_reset_ctrl: got de=%b hs=%b vs=%b fs=%b le=%b want all 0", vid.de, vid.hsync, vid.vsync, vid.frame_start, vid.line_end);
        end
        repeat (3) @(negedge clk);
        total++; if (vid.de !== 1'b0 || vid.fb_rd_en !== 1'b0) begin bad++; $display("FAIL reset_hold: got de=%b rd_en=%b want 0 0", vid.de, vid.fb_rd_en); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (vid.fb_rd_en !== 1'b1 || vid.fb_addr !== 19'd0) begin bad++; $display("FAIL restart_read: got rd_en=%b addr=%0d want 1 0", vid.fb_rd_en, vid.fb_addr); end
        @(negedge clk);
        total++; if (vid.de !== 1'b0) begin bad++; $display("FAIL restart_de_early: got %b want 0", vid.de); end
        @(negedge clk);
        total++; if (vid.de !== 1'b1 || vid.frame_start !== 1'b1 || vid.color !== 8'h00) begin
            bad++; $display("FAIL restart_first_pixel: got de=%b fs=%b color=%0h want 1 1 00", vid.de, vid.frame_start, vid.color);
        end
    endtask

`ifdef FB_SCANOUT_SWAP_EN
    task automatic test_swap();
        int acks = 0, ack_n = -1, addr_after = -1;
        logic prev_rd = 1'b0;
        repeat (40) @(negedge clk);
        vid.swap_req = 1'b1; @(negedge clk); vid.swap_req = 1'b0;
        repeat (30) @(negedge clk);
        vid.swap_req = 1'b1; @(negedge clk); vid.swap_req = 1'b0;
        for (int n = 0; n < 2 * FT; n++) begin
            @(negedge clk);
            if (vid.swap_ack) begin acks++; if (ack_n < 0) ack_n = n; end
            if (ack_n >= 0 && addr_after < 0 && vid.fb_rd_en && !prev_rd) addr_after = int'(vid.fb_addr);
            prev_rd = vid.fb_rd_en;
        end
        total++; if (acks != 1) begin bad++; $display("FAIL swap_ack_count: got %0d want 1", acks); end
        total++; if (vid.buf_sel !== 1'b1) begin bad++; $display("FAIL swap_buf_sel: got %b want 1", vid.buf_sel); end
        total++; if (addr_after != NPIX) begin bad++; $display("FAIL swap_first_addr: got %0d want %0d", addr_after, NPIX); end
    endtask
`endif

    initial begin
`ifdef FB_SCANOUT_SWAP_EN
        vid.swap_req = 1'b0;
`endif
        rst_n = 1'b0;
        test_reset();
        test_frame();
        test_reset_mid();
`ifdef FB_SCANOUT_SWAP_EN
        test_swap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
